// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller.
// Holds the FSM state type, the round count for each key size and
// the number of state columns processed by MixColumns.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARK   = 3'd1,
    SUB   = 3'd2,
    SHIFT = 3'd3,
    MIX   = 3'd4,
    DONE  = 3'd5
  } aes_state_e;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  localparam int NUM_COLS = 4;

endpackage

// File: rtl/aes_round_cnt.sv
// Round counter for the AES round controller.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clr       : return the count to 0
//   inc       : advance to the next round (held once NR is reached)
//   round     : current round index, 0..NR
//   last      : high while round == NR
module aes_round_cnt #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] round,
  output logic       last
);

  localparam logic [3:0] NR_VAL = 4'(NR);

  assign last = (round == NR_VAL);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      round <= 4'd0;
    end else if (inc && !last) begin
      round <= round + 4'd1;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencing controller.
// Walks one block through the initial AddRoundKey and NR rounds of
// SubBytes / ShiftRows / MixColumns (column-serial) / AddRoundKey,
// skipping MixColumns in the final round.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start        : begin one block (only looked at in IDLE)
//   key_valid    : round key for `round` is available
//   busy, done   : activity flag and one-cycle completion pulse
//   round        : current round index, 0..NR
//   key_req      : round key for `round` requested
//   ark_en, sub_en, shift_en, mix_en : datapath write strobes
//   column_index : MixColumns column, 0..3 (0 outside MIX)
//   final_round  : high while round == NR
//
// state | meaning
// IDLE  | waiting for start
// ARK   | AddRoundKey, stalls until key_valid
// SUB   | SubBytes, one cycle
// SHIFT | ShiftRows, one cycle
// MIX   | MixColumns, one column per cycle
// DONE  | ciphertext valid, one cycle
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] round,
  output logic       key_req,
  output logic       ark_en,
  output logic       sub_en,
  output logic       shift_en,
  output logic [1:0] column_index,
  output logic       mix_en,
  output logic       final_round
);

  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  aes_state_e state;
  logic       last;

  // key_req is registered high for exactly the ARK cycles, so this is the
  // only output with a path from an input.
  assign ark_en      = key_req & key_valid;
  assign final_round = last;

  aes_round_cnt #(.NR(NR)) u_round_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == DONE),
    .inc   (ark_en),
    .round (round),
    .last  (last)
  );

  // Outputs are loaded with the values belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      key_req      <= 1'b0;
      sub_en       <= 1'b0;
      shift_en     <= 1'b0;
      mix_en       <= 1'b0;
      column_index <= 2'd0;
    end else begin
      done     <= 1'b0;
      sub_en   <= 1'b0;
      shift_en <= 1'b0;
      mix_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ARK;
            busy    <= 1'b1;
            key_req <= 1'b1;
          end
        end
        ARK: begin
          if (key_valid) begin
            key_req <= 1'b0;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= SUB;
              sub_en <= 1'b1;
            end
          end
        end
        SUB: begin
          state    <= SHIFT;
          shift_en <= 1'b1;
        end
        SHIFT: begin
          if (last) begin
            state   <= ARK;
            key_req <= 1'b1;
          end else begin
            state        <= MIX;
            mix_en       <= 1'b1;
            column_index <= 2'd0;
          end
        end
        MIX: begin
          if (column_index == LAST_COL) begin
            state        <= ARK;
            key_req      <= 1'b1;
            column_index <= 2'd0;
          end else begin
            mix_en       <= 1'b1;
            column_index <= column_index + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          key_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  localparam int NR = 10;

  localparam int K_ARK   = 0;
  localparam int K_SUB   = 1;
  localparam int K_SHIFT = 2;
  localparam int K_MIX   = 3;
  localparam int K_DONE  = 4;

  typedef struct {
    int kind;
    int rnd;
    int col;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       key_valid;
  logic       busy;
  logic       done;
  logic [3:0] round;
  logic       key_req;
  logic       ark_en;
  logic       sub_en;
  logic       shift_en;
  logic [1:0] column_index;
  logic       mix_en;
  logic       final_round;

  int total = 0;
  int bad   = 0;

  step_t q[$];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key_valid    (key_valid),
    .busy         (busy),
    .done         (done),
    .round        (round),
    .key_req      (key_req),
    .ark_en       (ark_en),
    .sub_en       (sub_en),
    .shift_en     (shift_en),
    .column_index (column_index),
    .mix_en       (mix_en),
    .final_round  (final_round)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected sequence of operations for one block, from the round structure:
  // initial ARK, then SUB/SHIFT/MIX x4/ARK per round, no MIX in the last round.
  task automatic build_q();
    q.delete();
    q.push_back('{K_ARK, 0, 0});
    for (int r = 1; r <= NR; r++) begin
      q.push_back('{K_SUB, r, 0});
      q.push_back('{K_SHIFT, r, 0});
      if (r < NR) begin
        for (int c = 0; c < 4; c++) q.push_back('{K_MIX, r, c});
      end
      q.push_back('{K_ARK, r, 0});
    end
    q.push_back('{K_DONE, NR, 0});
  endtask

  task automatic check_step(input step_t s, input logic kv);
    chk("busy",         32'(busy),         32'(1));
    chk("done",         32'(done),         32'(s.kind == K_DONE));
    chk("round",        32'(round),        32'(s.rnd));
    chk("key_req",      32'(key_req),      32'(s.kind == K_ARK));
    chk("ark_en",       32'(ark_en),       32'(s.kind == K_ARK && kv));
    chk("sub_en",       32'(sub_en),       32'(s.kind == K_SUB));
    chk("shift_en",     32'(shift_en),     32'(s.kind == K_SHIFT));
    chk("mix_en",       32'(mix_en),       32'(s.kind == K_MIX));
    chk("column_index", 32'(column_index), 32'((s.kind == K_MIX) ? s.col : 0));
    chk("final_round",  32'(final_round),  32'(s.rnd == NR));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},     32'(busy),         32'(0));
    chk({tag, "_done"},     32'(done),         32'(0));
    chk({tag, "_round"},    32'(round),        32'(0));
    chk({tag, "_col"},      32'(column_index), 32'(0));
    chk({tag, "_key_req"},  32'(key_req),      32'(0));
    chk({tag, "_enables"},  32'({ark_en, sub_en, shift_en, mix_en}), 32'(0));
    chk({tag, "_final"},    32'(final_round),  32'(0));
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  // mode 0: key always valid; 1: five-cycle key stall in round-5 ARK; 2: random key_valid.
  task automatic run_block(input int mode, input bit poke_start, input bit abort,
                           output int done_at, output int stalls);
    int    n;
    int    nsub;
    int    nmix;
    int    nark;
    int    stall_left;
    bit    fin;
    logic  kv;
    step_t h;
    build_q();
    n = 0; nsub = 0; nmix = 0; nark = 0; stall_left = 5; fin = 0;
    stalls = 0; done_at = -1;
    start = 1'b1;
    @(negedge clk);
    check_idle("pre_start");
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int it = 0; it < 400 && !fin; it++) begin
      h = q[0];
      case (mode)
        1:       kv = !(h.kind == K_ARK && h.rnd == 5 && stall_left > 0);
        2:       kv = ($urandom_range(0, 3) != 0);
        default: kv = 1'b1;
      endcase
      if (mode == 1 && !kv) stall_left--;
      if (h.kind == K_ARK && !kv) stalls++;
      key_valid = kv;
      start = poke_start && (h.rnd == 7);
      @(negedge clk);
      check_step(h, kv);
      if (sub_en) nsub++;
      if (mix_en) nmix++;
      if (ark_en) nark++;
      if (abort && h.kind == K_MIX && h.rnd == 4 && h.col == 2) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        key_valid = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_idle("after_abort");
        @(posedge clk);
        #1;
        return;
      end
      if (h.kind == K_DONE) begin
        done_at = n;
        fin = 1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!(h.kind == K_ARK && !kv)) void'(q.pop_front());
    end
    start = 1'b0;
    key_valid = 1'b1;
    if (!fin) begin
      chk("timeout_no_done", 32'(0), 32'(1));
    end else begin
      chk("sub_count", 32'(nsub), 32'(NR));
      chk("mix_count", 32'(nmix), 32'(4 * (NR - 1)));
      chk("ark_count", 32'(nark), 32'(NR + 1));
    end
  endtask

  initial begin
    int d;
    int s;
    rst = 1'b1;
    start = 1'b0;
    key_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // No start: must stay idle.
    repeat (3) begin
      @(negedge clk);
      check_idle("idle_hold");
    end
    @(posedge clk);
    #1;

    run_block(0, 0, 0, d, s);
    chk("done_latency", 32'(d), 32'(67));

    run_block(1, 0, 0, d, s);
    chk("stall_latency", 32'(d), 32'(72));
    chk("stall_cycles", 32'(s), 32'(5));

    run_block(0, 0, 1, d, s);
    run_block(0, 0, 0, d, s);
    chk("after_reset_latency", 32'(d), 32'(67));

    // start poked during round 7 is ignored; next block starts right after done.
    run_block(0, 1, 0, d, s);
    chk("poke_latency", 32'(d), 32'(67));
    run_block(0, 0, 0, d, s);
    chk("back_to_back_latency", 32'(d), 32'(67));

    for (int i = 0; i < 3; i++) begin
      run_block(2, 0, 0, d, s);
      chk("rand_latency", 32'(d), 32'(67 + s));
    end

    @(negedge clk);
    check_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL provide parameter: NR, 10, number of AES rounds (10/12/14 for AES-128/192/256).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: start  input  1  begin one block encryption; sampled only in IDLE.
REQ-005 SHALL provide port: key_valid  input  1  round key for current round index is present.
REQ-006 SHALL provide port: busy  output  1  high in every state except IDLE.
REQ-007 SHALL provide port: done  output  1  one-cycle pulse, ciphertext state valid.
REQ-008 SHALL provide port: round  output  4  current round index, 0..NR.
REQ-009 SHALL provide port: key_req  output  1  round key for `round` requested.
REQ-010 SHALL provide port: ark_en  output  1  AddRoundKey result writes state this cycle.
REQ-011 SHALL provide port: sub_en  output  1  SubBytes result writes state this cycle.
REQ-012 SHALL provide port: shift_en  output  1  ShiftRows buffer loads this cycle.
REQ-013 SHALL provide port: column_index  output  2  column presented to MixColumns, 0..3.
REQ-014 SHALL provide port: mix_en  output  1  MixColumns result for column_index writes state.
REQ-015 SHALL provide port: final_round  output  1  high while round == NR.

Function
REQ-016 FSM states SHALL be IDLE, ARK, SUB, SHIFT, MIX, DONE.
REQ-017 IDLE: start=1 -> ARK with round=0; start=0 -> stay.
REQ-018 ARK: key_req=1 throughout; ark_en=1 only in the cycle key_valid=1; key_valid=0 -> stall in ARK, no other enable high.
REQ-019 ARK exit on key_valid=1: round==NR -> DONE; else round increments, next SUB.
REQ-020 SUB: sub_en=1 for one cycle -> SHIFT.
REQ-021 SHIFT: shift_en=1 for one cycle; round<NR -> MIX with column_index=0; round==NR -> ARK (MixColumns skipped).
REQ-022 MIX: mix_en=1 every cycle; column_index steps 0,1,2,3; after column 3 -> ARK; column_index wraps to 0.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE; round held at NR until IDLE, then cleared to 0.
REQ-024 At most one of ark_en, sub_en, shift_en, mix_en SHALL be high in any cycle.
REQ-025 column_index SHALL be 0 in all states other than MIX.
REQ-026 start while busy=1 SHALL be ignored, no queuing.
REQ-027 With key_valid held 1, done SHALL rise 4+7*(NR-1) cycles after the start-sampling edge (67 cycles for NR=10); each ARK stall cycle adds exactly one cycle.
REQ-028 round increment SHALL saturate logic-free: round never exceeds NR; width 4 covers NR<=14.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, round=0, column_index=0, all enables, key_req, busy, done=0, regardless of current state (including mid-MIX or ARK stall).
REQ-030 After reset release, the first start sampled in IDLE SHALL begin a full sequence from round 0.

Structure
REQ-031 Shared package aes_pkg SHALL hold the FSM state type, NR defaults per key size, and the column count constant (4).
REQ-032 One sub-module aes_round_cnt SHALL hold the round counter (clear, increment, equals-NR flag); column stepping stays in the FSM.
REQ-033 All outputs SHALL be decoded from registered state; no combinational path from start or key_valid to any output other than ark_en.

Verification
REQ-034 NR=10, key_valid=1, start pulse -> done 67 cycles later; sub_en count 10, mix_en count 36, ark_en count 11.
REQ-035 Round 3 MIX -> column_index sequence 0,1,2,3 on consecutive cycles with mix_en=1, then ark_en with round=3.
REQ-036 key_valid=0 for 5 cycles in round-5 ARK -> key_req held, no enables, done delayed to cycle 72.
REQ-037 rst=1 during round 4 MIX column 2 -> next cycle busy=0, round=0, column_index=0; new start completes in 67 cycles.
REQ-038 start re-asserted during round 7 -> ignored; single done pulse; start in the cycle after done -> second block begins.
REQ-039 Final round -> SHIFT goes directly to ARK; no mix_en while final_round=1.
